// File: rtl/lbp_pkg.sv
// Shared types and helpers for the LBP engine: FSM states, neighbour bit
// positions and the classic-to-riu2 code conversion.
package lbp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lbp_state_t;

  localparam int B_TL = 0;
  localparam int B_T  = 1;
  localparam int B_TR = 2;
  localparam int B_L  = 3;
  localparam int B_R  = 4;
  localparam int B_BL = 5;
  localparam int B_B  = 6;
  localparam int B_BR = 7;

  // Walk around the centre clockwise starting at the top-left neighbour.
  localparam int CIRC_ORDER [8] = '{B_TL, B_T, B_TR, B_R, B_BR, B_B, B_BL, B_L};

  localparam logic [7:0] LBP_UNIFORM_NONUNI = 8'd9;

  function automatic logic [7:0] classic_to_riu2(input logic [7:0] code);
    logic [3:0] trans;
    logic [3:0] ones;
    trans = '0;
    ones  = '0;
    for (int i = 0; i < 8; i++) begin
      trans = trans + {3'd0, code[CIRC_ORDER[i]] ^ code[CIRC_ORDER[(i + 1) % 8]]};
      ones  = ones + {3'd0, code[CIRC_ORDER[i]]};
    end
    return (trans <= 4'd2) ? {4'd0, ones} : LBP_UNIFORM_NONUNI;
  endfunction

endpackage

// File: rtl/lbp_line_buffer.sv
// Two-row delay indexed by column: taps return the pixels one and two rows
// above the current column; both rows shift down on every accepted pixel.
module lbp_line_buffer #(
  parameter int IMG_W  = 128,
  parameter int DATA_W = 8,
  localparam int COL_W = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [COL_W-1:0]  col,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2
);

  logic [DATA_W-1:0] row1 [IMG_W];
  logic [DATA_W-1:0] row2 [IMG_W];

  assign tap1 = row1[col];
  assign tap2 = row2[col];

  always_ff @(posedge clk) begin
    if (we) begin
      row2[col] <= row1[col];
      row1[col] <= din;
    end
  end

endmodule

// File: rtl/lbp_engine_param.sv
// Raster-order LBP engine: reads each gray pixel once, keeps a 3x3 window fed
// by two line buffers and writes one classic or riu2 code per interior pixel.
module lbp_engine_param
  import lbp_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  input  logic              mode,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish,
  output lbp_state_t        dbg_state
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] CENTRE_OFS = ADDR_W'(IMG_W + 1);

  lbp_state_t        state;
  logic [COL_W-1:0]  x;
  logic [ROW_W-1:0]  y;
  logic              mode_q;
  logic [DATA_W-1:0] col0 [3];
  logic [DATA_W-1:0] col1 [3];
  logic [DATA_W-1:0] tap1, tap2;
  logic              accept, emit, last_px;
  logic [7:0]        code, code_out;

  // Handshake: a pixel is transferred on a rising edge where gray_req is
  // high; gray_req follows gray_ready only while reading, so a low
  // gray_ready freezes cursor, window and line buffers.
  assign accept    = (state == ST_READ) && gray_ready;
  assign gray_req  = accept;
  assign dbg_state = state;
  assign emit      = (x >= COL_W'(2)) && (y >= ROW_W'(2));
  assign last_px   = (x == COL_W'(IMG_W - 1)) && (y == ROW_W'(IMG_H - 1));

  lbp_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_line_buffer (
    .clk  (clk),
    .we   (accept),
    .col  (x),
    .din  (gray_data),
    .tap1 (tap1),
    .tap2 (tap2)
  );

  // The window is evaluated with the incoming column (tap2, tap1, gray_data)
  // as its right edge, so the code is ready on the accepting edge.
  always_comb begin
    code       = '0;
    code[B_TL] = col0[0] >= col1[1];
    code[B_T]  = col1[0] >= col1[1];
    code[B_TR] = tap2 >= col1[1];
    code[B_L]  = col0[1] >= col1[1];
    code[B_R]  = tap1 >= col1[1];
    code[B_BL] = col0[2] >= col1[1];
    code[B_B]  = col1[2] >= col1[1];
    code[B_BR] = gray_data >= col1[1];
    code_out   = mode_q ? classic_to_riu2(code) : code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      gray_addr <= '0;
      mode_q    <= 1'b0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        col0[i] <= '0;
        col1[i] <= '0;
      end
    end else begin
      lbp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gray_ready) begin
            mode_q <= mode;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (accept) begin
            col0    <= col1;
            col1[0] <= tap2;
            col1[1] <= tap1;
            col1[2] <= gray_data;
            if (emit) begin
              lbp_valid <= 1'b1;
              lbp_addr  <= gray_addr - CENTRE_OFS;
              lbp_data  <= code_out;
            end
            if (last_px) begin
              state <= ST_DRAIN;
            end else begin
              gray_addr <= gray_addr + 1'b1;
              if (x == COL_W'(IMG_W - 1)) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          state  <= ST_DONE;
          finish <= 1'b1;
        end
        default: begin
          finish <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lbp_engine_param.md
Name: lbp_engine_param

Overview:
Parametrised Local Binary Pattern engine for grayscale images of arbitrary size IMG_W x IMG_H. It reads every pixel exactly once in raster order from the gray memory and keeps a 3x3 window in two line buffers. It writes one 8-bit LBP code per interior pixel to the LBP memory. It adds a run-time uniform (riu2) mode and gray_ready back-pressure stalls, and it is the drop-in successor of the fixed 128x128 LBP block.

Parameters:
IMG_W, 128, image width in pixels (>=3)
IMG_H, 128, image height in pixels (>=3)
DATA_W, 8, gray pixel width
ADDR_W, 14, address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
gray_ready  in  1  gray memory ready; frame starts and reading proceeds only while high
gray_req  out  1  read request for gray_addr this cycle
gray_addr  out  ADDR_W  raster address y*IMG_W+x of requested pixel
gray_data  in  DATA_W  pixel data, valid in the same cycle as gray_req, sampled at next rising edge
mode  in  1  0 = classic LBP, 1 = rotation-invariant uniform (riu2); sampled at frame start
lbp_valid  out  1  one-cycle write strobe
lbp_addr  out  ADDR_W  raster address of the centre pixel being written
lbp_data  out  8  LBP code
finish  out  1  frame complete; held high until reset

Behaviour:
- Reset (async, any time including mid-frame): all outputs go 0 immediately; FSM -> IDLE; cursor, window and mode register cleared. No partial-frame state survives.
- FSM states:
  - IDLE: when gray_ready=1, latch mode, go to READ (no request in the IDLE cycle).
  - READ: gray_req = gray_ready; gray_addr = cursor (y,x). A pixel is accepted on the rising edge when gray_req=1. On acceptance the cursor advances x, then y. After acceptance of (IMG_H-1, IMG_W-1), go to DRAIN.
  - DRAIN: 1 cycle to emit the last result, then go to DONE.
  - DONE: finish=1, gray_req=0; the FSM remains in DONE until reset.
- Stall: gray_ready=0 in READ -> gray_req=0, the cursor, window and line buffers hold, and no new lbp_valid is issued.
- Window: line buffers hold rows y-1 and y-2 (2*IMG_W*DATA_W storage); a 3x3 shift window is fed by the accepted pixel plus both buffer taps at column x.
- Output rule: accepting pixel (y,x) with y>=2 and x>=2 completes the window for centre (y-1,x-1).
  - lbp_valid=1 on the next cycle, with lbp_addr=(y-1)*IMG_W+(x-1). Latency is 1 cycle after the accepting edge.
  - Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never written; the consumer memory is pre-cleared to 0.
  - There are exactly (IMG_W-2)*(IMG_H-2) writes per frame, in raster order.
  - The window must not wrap across row ends: pixels with x<2 produce no output.
- Classic code: bit = (neighbour >= centre), unsigned compare. Bit order: b0 TL, b1 T, b2 TR, b3 L, b4 R, b5 BL, b6 B, b7 BR.
- Uniform code (mode=1):
  - Take bits in circular order TL,T,TR,R,BR,B,BL,L and count 0/1 transitions, including the L->TL wrap.
  - If transitions <= 2, lbp_data = popcount (0..8); otherwise lbp_data = 9.
- mode changes mid-frame are ignored.
- finish rises the cycle after the final lbp_valid and remains high.
- lbp_data/lbp_addr are don't-care when lbp_valid=0, but are driven 0 after reset.

Decomposition:
- Package lbp_pkg: FSM state enum (IDLE, READ, DRAIN, DONE), neighbour bit-index constants, circular-order table, LBP_UNIFORM_NONUNI=9, function for classic-to-riu2 conversion.
- Sub-module lbp_line_buffer (params IMG_W, DATA_W): two-row register/RAM delay with write-enable = accept. It outputs taps row-1 and row-2 at the current column.

Test Plan:
- IMG_W=IMG_H=4, all pixels 0x50, mode=0 -> 4 writes at addr 5,6,9,10 with data 0xFF, then finish=1; no other lbp_valid.
- 3x3 image, centre 10, TL=20, others 5, mode=0 -> single write addr 4 data 0x01; same image mode=1 -> data 0x01 (2 transitions, popcount 1).
- 3x3, centre 10, T/L/R/B=20, corners 5: mode=0 -> 0x5A; mode=1 -> 9 (8 transitions).
- 4x4 random image with gray_ready dropped for 5 cycles after the 7th accept -> gray_req=0 and no lbp_valid during the stall; the write sequence and data are identical to the unstalled run.
- Reset pulsed mid-frame at the 10th accept -> all outputs 0 asynchronously; the restart produces a complete, correct frame with exactly one finish.
- Default 128x128 random image vs the golden C model, both modes -> 15876 writes, zero mismatches, no border address written, finish held high.
